// File: rtl/hrf_regfile_v2.sv
// rtl/hrf_regfile_v2.sv - parametrised multi-port vector register file with clearing sequencer
//
// Purpose: vector register file between issue and the polynomial/NTT units.
//   Reg 0 reads zero and reg 1 reads all-ones; writes to either are dropped.
//   Reads are registered with one-cycle latency.
//   After rst, an INIT sequencer clears regs 2..DEPTH-1 one per cycle, then raises rf_ready.
// Optional feature macro: RF_BYPASS_EN (write-first forwarding of same-cycle winning writes).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   rf_ready             - initialised and accepting traffic
//   rf_src1/rf_src2      - per-port read addresses (AR_BITS x RDPORTS, packed)
//   rf_srcv1/rf_srcv2    - registered read data (XLEN x RDPORTS, packed)
//   rf_we/rf_dst/rf_dstv - per-port write enable, address, data (WRPORTS)
//   rf_wr_conflict       - pulse: >=2 enabled ports hit one writable address last cycle
module hrf_regfile_v2 #(
    parameter int XLEN    = 1024,
    parameter int DEPTH   = 32,
    parameter int RDPORTS = 3,
    parameter int WRPORTS = 3,
    parameter int AR_BITS = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rf_ready,
    input  logic [AR_BITS*RDPORTS-1:0] rf_src1,
    input  logic [AR_BITS*RDPORTS-1:0] rf_src2,
    output logic [XLEN*RDPORTS-1:0]    rf_srcv1,
    output logic [XLEN*RDPORTS-1:0]    rf_srcv2,
    input  logic [WRPORTS-1:0]         rf_we,
    input  logic [AR_BITS*WRPORTS-1:0] rf_dst,
    input  logic [XLEN*WRPORTS-1:0]    rf_dstv,
    output logic                       rf_wr_conflict
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                    state_q, state_d;
    logic [AR_BITS-1:0]        cnt_q, cnt_d;
    logic                      ready_q, ready_d;
    logic                      conflict_q, conflict_d;
    logic [XLEN*RDPORTS-1:0]   srcv1_q, srcv1_d;
    logic [XLEN*RDPORTS-1:0]   srcv2_q, srcv2_d;
    logic [XLEN-1:0]           mem_q [DEPTH];
    logic [XLEN-1:0]           mem_d [DEPTH];
    logic [WRPORTS-1:0]        wr_en;

    assign rf_ready       = ready_q;
    assign rf_srcv1       = srcv1_q;
    assign rf_srcv2       = srcv2_q;
    assign rf_wr_conflict = conflict_q;

    // A port takes part in writes (and in conflict detection) only when the
    // file is ready and it targets a writable register.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < WRPORTS; i++) begin
            wr_en[i] = rf_we[i] && ready_q &&
                       (rf_dst[i*AR_BITS +: AR_BITS] >= AR_BITS'(2));
        end
    end

    // Read value seen by an address this cycle, including the constant override.
    function automatic logic [XLEN-1:0] rd_word(input logic [AR_BITS-1:0] addr);
        logic [XLEN-1:0] v;
        v = mem_q[addr];
`ifdef RF_BYPASS_EN
        // Ascending scan so the highest-index matching port is forwarded.
        for (int i = 0; i < WRPORTS; i++) begin
            if (wr_en[i] && (rf_dst[i*AR_BITS +: AR_BITS] == addr))
                v = rf_dstv[i*XLEN +: XLEN];
        end
`endif
        if (addr == AR_BITS'(0))
            v = '0;
        else if (addr == AR_BITS'(1))
            v = '1;
        return v;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        conflict_d = 1'b0;
        srcv1_d    = '0;
        srcv2_d    = '0;
        mem_d      = mem_q;
        if (state_q == ST_INIT) begin
            mem_d[cnt_q] = '0;
            if (cnt_q == AR_BITS'(DEPTH - 1)) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end else begin
                cnt_d = cnt_q + AR_BITS'(1);
            end
        end else begin
            // Later ports overwrite earlier ones: highest index wins.
            for (int i = 0; i < WRPORTS; i++) begin
                if (wr_en[i])
                    mem_d[rf_dst[i*AR_BITS +: AR_BITS]] = rf_dstv[i*XLEN +: XLEN];
            end
            for (int i = 0; i < WRPORTS; i++) begin
                for (int j = i + 1; j < WRPORTS; j++) begin
                    if (wr_en[i] && wr_en[j] &&
                        (rf_dst[i*AR_BITS +: AR_BITS] == rf_dst[j*AR_BITS +: AR_BITS]))
                        conflict_d = 1'b1;
                end
            end
            for (int p = 0; p < RDPORTS; p++) begin
                srcv1_d[p*XLEN +: XLEN] = rd_word(rf_src1[p*AR_BITS +: AR_BITS]);
                srcv2_d[p*XLEN +: XLEN] = rd_word(rf_src2[p*AR_BITS +: AR_BITS]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= AR_BITS'(2);
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
            srcv1_q    <= '0;
            srcv2_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
            srcv1_q    <= srcv1_d;
            srcv2_q    <= srcv2_d;
        end
    end

    // Storage has no reset of its own; INIT clears it. Writes in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!rst)
            mem_q <= mem_d;
    end

endmodule

// File: tb/tb_hrf_regfile_v2.sv
// tb/tb_hrf_regfile_v2.sv - self-checking bench for hrf_regfile_v2
module tb_hrf_regfile_v2;

    localparam int XLEN    = 64;
    localparam int DEPTH   = 32;
    localparam int RDPORTS = 3;
    localparam int WRPORTS = 3;
    localparam int AR      = $clog2(DEPTH);
    localparam logic [XLEN-1:0] ONES = '1;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rf_ready;
    logic [AR*RDPORTS-1:0] src1_pk, src2_pk;
    logic [XLEN*RDPORTS-1:0] rf_srcv1, rf_srcv2;
    logic [WRPORTS-1:0]    we;
    logic [AR*WRPORTS-1:0] dst_pk;
    logic [XLEN*WRPORTS-1:0] dv_pk;
    logic                  rf_wr_conflict;

    logic [AR-1:0]   s1 [RDPORTS];
    logic [AR-1:0]   s2 [RDPORTS];
    logic [AR-1:0]   dst [WRPORTS];
    logic [XLEN-1:0] dv [WRPORTS];

    for (genvar p = 0; p < RDPORTS; p++) begin : g_rd
        assign src1_pk[p*AR +: AR] = s1[p];
        assign src2_pk[p*AR +: AR] = s2[p];
    end
    for (genvar i = 0; i < WRPORTS; i++) begin : g_wr
        assign dst_pk[i*AR +: AR]     = dst[i];
        assign dv_pk[i*XLEN +: XLEN]  = dv[i];
    end

    hrf_regfile_v2 #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RDPORTS(RDPORTS), .WRPORTS(WRPORTS), .AR_BITS(AR)
    ) dut (
        .clk(clk), .rst(rst), .rf_ready(rf_ready),
        .rf_src1(src1_pk), .rf_src2(src2_pk),
        .rf_srcv1(rf_srcv1), .rf_srcv2(rf_srcv2),
        .rf_we(we), .rf_dst(dst_pk), .rf_dstv(dv_pk),
        .rf_wr_conflict(rf_wr_conflict)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural register contents plus init countdown.
    logic [XLEN-1:0] regs [DEPTH];
    bit              m_ready = 1'b0;
    int              m_left  = DEPTH - 2;

    task automatic chk(input string nm, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model_read(input int a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        if (a == 1) return ONES;
        v = regs[a];
        if (BYP) begin
            for (int i = 0; i < WRPORTS; i++)
                if (we[i] && int'(dst[i]) == a) v = dv[i];
        end
        return v;
    endfunction

    // Applies current inputs for one clock, advances the model, compares all outputs.
    task automatic do_cycle();
        logic [XLEN-1:0] e1 [RDPORTS];
        logic [XLEN-1:0] e2 [RDPORTS];
        logic e_conf, e_ready;
        int hits [DEPTH];
        e_conf = 1'b0;
        for (int p = 0; p < RDPORTS; p++) begin
            e1[p] = '0;
            e2[p] = '0;
        end
        if (rst) begin
            m_ready = 1'b0;
            m_left  = DEPTH - 2;
            for (int r = 0; r < DEPTH; r++) regs[r] = '0;
            e_ready = 1'b0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
            e_ready = m_ready;
        end else begin
            for (int p = 0; p < RDPORTS; p++) begin
                e1[p] = model_read(int'(s1[p]));
                e2[p] = model_read(int'(s2[p]));
            end
            for (int a = 0; a < DEPTH; a++) hits[a] = 0;
            for (int i = 0; i < WRPORTS; i++)
                if (we[i] && dst[i] >= 2) hits[dst[i]]++;
            for (int a = 0; a < DEPTH; a++)
                if (hits[a] > 1) e_conf = 1'b1;
            for (int i = 0; i < WRPORTS; i++)
                if (we[i] && dst[i] >= 2) regs[dst[i]] = dv[i];
            e_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rf_ready", XLEN'(rf_ready), XLEN'(e_ready));
        chk("rf_wr_conflict", XLEN'(rf_wr_conflict), XLEN'(e_conf));
        for (int p = 0; p < RDPORTS; p++) begin
            chk($sformatf("rf_srcv1[%0d]", p), rf_srcv1[p*XLEN +: XLEN], e1[p]);
            chk($sformatf("rf_srcv2[%0d]", p), rf_srcv2[p*XLEN +: XLEN], e2[p]);
        end
    endtask

    task automatic rand_inputs();
        we = WRPORTS'($urandom);
        for (int i = 0; i < WRPORTS; i++) begin
            dst[i] = AR'($urandom_range(0, 9));
            dv[i]  = {$urandom, $urandom};
        end
        for (int p = 0; p < RDPORTS; p++) begin
            s1[p] = AR'($urandom_range(0, DEPTH - 1));
            s2[p] = AR'($urandom_range(0, 9));
        end
    endtask

    task automatic idle_inputs();
        we = '0;
        for (int i = 0; i < WRPORTS; i++) begin
            dst[i] = '0;
            dv[i]  = '0;
        end
        for (int p = 0; p < RDPORTS; p++) begin
            s1[p] = '0;
            s2[p] = '0;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!rf_ready && n < 40) begin
            do_cycle();
            n++;
        end
    endtask

    typedef struct {
        logic [2:0]      we;
        int              d0, d1, d2;
        logic [XLEN-1:0] v0, v1, v2;
        int              r1, r2;
        logic [XLEN-1:0] x1, x2;
        logic            xc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // we, d0,d1,d2, v0,v1,v2, r1 (src1[0]), r2 (src2[2]), x1, x2, conflict
        tbl[0]  = '{3'b001, 0, 0, 0, 64'hA5, 64'h0, 64'h0, 0, 1, 64'h0, ONES, 1'b0};
        tbl[1]  = '{3'b001, 1, 0, 0, 64'hA5, 64'h0, 64'h0, 1, 0, ONES, 64'h0, 1'b0};
        tbl[2]  = '{3'b011, 0, 0, 0, 64'hA5, 64'hA5, 64'h0, 0, 1, 64'h0, ONES, 1'b0};
        tbl[3]  = '{3'b010, 0, 5, 0, 64'h0, 64'h1234, 64'h0, 2, 3, 64'h0, 64'h0, 1'b0};
        tbl[4]  = '{3'b000, 0, 0, 0, 64'h0, 64'h0, 64'h0, 5, 5, 64'h1234, 64'h1234, 1'b0};
        tbl[5]  = '{3'b111, 7, 7, 7, 64'h1, 64'h2, 64'h3, 7, 7,
                    BYP ? 64'h3 : 64'h0, BYP ? 64'h3 : 64'h0, 1'b1};
        tbl[6]  = '{3'b000, 0, 0, 0, 64'h0, 64'h0, 64'h0, 7, 7, 64'h3, 64'h3, 1'b0};
        tbl[7]  = '{3'b001, 9, 0, 0, 64'h5555, 64'h0, 64'h0, 9, 9,
                    BYP ? 64'h5555 : 64'h0, BYP ? 64'h5555 : 64'h0, 1'b0};
        tbl[8]  = '{3'b100, 0, 0, 9, 64'h0, 64'h0, 64'hBEEF, 9, 9,
                    BYP ? 64'hBEEF : 64'h5555, BYP ? 64'hBEEF : 64'h5555, 1'b0};
        tbl[9]  = '{3'b000, 0, 0, 0, 64'h0, 64'h0, 64'h0, 9, 9, 64'hBEEF, 64'hBEEF, 1'b0};
        tbl[10] = '{3'b101, 12, 0, 13, 64'h11, 64'h0, 64'h22, 12, 13,
                    BYP ? 64'h11 : 64'h0, BYP ? 64'h22 : 64'h0, 1'b0};
        tbl[11] = '{3'b011, 14, 14, 0, 64'h11, 64'h22, 64'h0, 14, 14,
                    BYP ? 64'h22 : 64'h0, BYP ? 64'h22 : 64'h0, 1'b1};
        tbl[12] = '{3'b000, 0, 0, 0, 64'h0, 64'h0, 64'h0, 14, 14, 64'h22, 64'h22, 1'b0};
        tbl[13] = '{3'b110, 0, 1, 1, 64'h0, 64'h9, 64'h9, 12, 13, 64'h11, 64'h22, 1'b0};

        // Reset held 3 cycles, then init must take exactly DEPTH-2 cycles.
        rst = 1'b1;
        idle_inputs();
        for (int k = 0; k < 3; k++) do_cycle();
        rst = 1'b0;
        rand_inputs();
        n = 0;
        while (!rf_ready && n < 40) begin
            rand_inputs();
            do_cycle();
            n++;
        end
        chk("init_cycles", XLEN'(n), XLEN'(DEPTH - 2));

        // Every register reads back its cleared value.
        idle_inputs();
        for (int r = 0; r < DEPTH; r += 2 * RDPORTS) begin
            for (int p = 0; p < RDPORTS; p++) begin
                s1[p] = AR'((r + p) % DEPTH);
                s2[p] = AR'((r + RDPORTS + p) % DEPTH);
            end
            do_cycle();
        end

        // Directed vectors.
        for (int k = 0; k < 14; k++) begin
            rand_inputs();
            we     = tbl[k].we;
            dst[0] = AR'(tbl[k].d0);
            dst[1] = AR'(tbl[k].d1);
            dst[2] = AR'(tbl[k].d2);
            dv[0]  = tbl[k].v0;
            dv[1]  = tbl[k].v1;
            dv[2]  = tbl[k].v2;
            s1[0]  = AR'(tbl[k].r1);
            s2[2]  = AR'(tbl[k].r2);
            do_cycle();
            chk($sformatf("vec%0d_srcv1[0]", k), rf_srcv1[0 +: XLEN], tbl[k].x1);
            chk($sformatf("vec%0d_srcv2[2]", k), rf_srcv2[2*XLEN +: XLEN], tbl[k].x2);
            chk($sformatf("vec%0d_conflict", k), XLEN'(rf_wr_conflict), XLEN'(tbl[k].xc));
        end

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            rst = ($urandom_range(0, 149) == 0);
            do_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        wait_ready(n);

        // Reset mid-operation discards the concurrent write and re-clears.
        idle_inputs();
        we[0] = 1'b1; dst[0] = AR'(10); dv[0] = 64'hFF;
        do_cycle();
        idle_inputs();
        rst = 1'b1;
        we[1] = 1'b1; dst[1] = AR'(11); dv[1] = 64'h77;
        do_cycle();
        rst = 1'b0;
        idle_inputs();
        wait_ready(n);
        chk("reinit_cycles", XLEN'(n), XLEN'(DEPTH - 2));
        s1[0] = AR'(10);
        s2[0] = AR'(11);
        do_cycle();
        chk("reg10_after_reset", rf_srcv1[0 +: XLEN], 64'h0);
        chk("reg11_after_reset", rf_srcv2[0 +: XLEN], 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
